// File: rtl/unary_scale_bounds_pkg.sv
// unary_pkg: shared state type, counter sizing and saturating multiply for unary scale blocks
package unary_pkg;
    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction
    function automatic logic [31:0] sat_mul(input logic [31:0] count, input logic [31:0] k, input logic [31:0] n);
        return (count * k > n) ? n : count * k;
    endfunction
endpackage

// File: rtl/unary_scale_bounds_if.sv
// unary_scale_bounds_if: input and output unary stream handshakes of the scaler
interface unary_scale_bounds_if #(
    parameter int K_WIDTH = 4
);
    logic a;
    logic a_valid;
    logic a_ready;
    logic [K_WIDTH-1:0] k;
    logic y;
    logic y_valid;
    logic y_ready;
    logic y_last;
    modport master (output a, a_valid, k, y_ready, input a_ready, y, y_valid, y_last);
    modport slave (input a, a_valid, k, y_ready, output a_ready, y, y_valid, y_last);
endinterface

// File: rtl/unary_scale_bounds_bound_calc.sv
// unary_bound_calc: running lower/upper bounds of min(k*popcount, N) for a partially seen frame
module unary_bound_calc import unary_pkg::*; #(
    parameter int STREAM_LEN = 32,
    parameter int K_WIDTH = 4,
    parameter int COUNT_WIDTH = count_width(STREAM_LEN)
) (
    input  logic [COUNT_WIDTH-1:0] o,
    input  logic [COUNT_WIDTH-1:0] i,
    input  logic [K_WIDTH-1:0]     k_q,
    output logic [COUNT_WIDTH-1:0] lower,
    output logic [COUNT_WIDTH-1:0] upper
);
    // upper assumes every unseen bit is a one
    assign lower = COUNT_WIDTH'(sat_mul(32'(o), 32'(k_q), 32'(STREAM_LEN)));
    assign upper = COUNT_WIDTH'(sat_mul(32'(o) + 32'(STREAM_LEN) - 32'(i), 32'(k_q), 32'(STREAM_LEN)));
endmodule

// File: rtl/unary_scale_bounds.sv
// unary_scale_bounds: streaming unary x k multiplier emitting output bits as soon as bounds fix them
module unary_scale_bounds import unary_pkg::*; #(
    parameter int STREAM_LEN = 32,
    parameter int K_WIDTH = 4,
    parameter int COUNT_WIDTH = count_width(STREAM_LEN)
) (
    input  logic                clk,
    input  logic                reset,
    unary_scale_bounds_if.slave bus,
    output logic                busy
);
    localparam logic [COUNT_WIDTH-1:0] N = COUNT_WIDTH'(STREAM_LEN);
    localparam logic [COUNT_WIDTH-1:0] ONE = COUNT_WIDTH'(1);
    state_t state;
    logic [COUNT_WIDTH-1:0] a_ones, a_count, y_ones, y_zeros, lower, upper, total;
    logic [K_WIDTH-1:0] k_q;
    logic accept, slot, can_emit, emit_one, emit_zero, last_hs, out_done, finish;

    unary_bound_calc #(.STREAM_LEN(STREAM_LEN), .K_WIDTH(K_WIDTH), .COUNT_WIDTH(COUNT_WIDTH)) u_bounds (
        .o(a_ones),
        .i(a_count),
        .k_q(k_q),
        .lower(lower),
        .upper(upper)
    );

    assign bus.a_ready = state == IDLE || (state == ACCUM && a_count < N);
    assign accept = bus.a_valid && bus.a_ready;
    assign total = y_ones + y_zeros;
    assign slot = !bus.y_valid || bus.y_ready;
    assign can_emit = slot && state != IDLE && total < N;
    assign emit_one = can_emit && y_ones < lower;
    assign emit_zero = can_emit && !emit_one && y_zeros < N - upper;
    assign last_hs = bus.y_valid && bus.y_ready && bus.y_last;
    assign out_done = last_hs || (total == N && !bus.y_valid);
    // output may complete while input is still arriving, so either side can close the frame
    assign finish = (state == DRAIN) ? last_hs : (state == ACCUM && accept && a_count == N - ONE && out_done);
    assign busy = state != IDLE;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_ones <= '0;
            a_count <= '0;
            y_ones <= '0;
            y_zeros <= '0;
            k_q <= '0;
            bus.y <= 1'b0;
            bus.y_valid <= 1'b0;
            bus.y_last <= 1'b0;
        end else begin
            if (slot) begin
                bus.y <= emit_one;
                bus.y_valid <= emit_one || emit_zero;
                bus.y_last <= (emit_one || emit_zero) && total == N - ONE;
                y_ones <= y_ones + COUNT_WIDTH'(emit_one);
                y_zeros <= y_zeros + COUNT_WIDTH'(emit_zero);
            end
            if (state == IDLE && accept) begin
                state <= ACCUM;
                k_q <= bus.k;
                a_count <= ONE;
                a_ones <= COUNT_WIDTH'(bus.a);
            end else if (accept) begin
                a_count <= a_count + ONE;
                a_ones <= a_ones + COUNT_WIDTH'(bus.a);
                if (a_count == N - ONE) state <= DRAIN;
            end
            if (finish) begin
                state <= IDLE;
                a_ones <= '0;
                a_count <= '0;
                y_ones <= '0;
                y_zeros <= '0;
            end
        end
    end
endmodule

// File: tb/tb_unary_scale_bounds.sv
// tb_unary_scale_bounds: directed vectors, stall/reset sequences and random frames against a bounds-based model
module tb_unary_scale_bounds;
    localparam int N = 8;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic busy;
    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] k;
        logic [7:0] bits;
        logic [7:0] seq;
        int lat;
    } vec_t;

    unary_scale_bounds_if #(.K_WIDTH(4)) bus ();
    unary_scale_bounds #(.STREAM_LEN(N), .K_WIDTH(4)) dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy));

    always #5 clk = ~clk;

    function automatic int mn(input int x, input int y);
        return x < y ? x : y;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_le(input string name, input int act, input int lim);
        checks++;
        if (act > lim) begin
            errors++;
            $display("FAIL %s: got %0d expected at most %0d", name, act, lim);
        end
    endtask

    // rmode: 0 always ready, 1 toggle, 2 random; first-beat k is kf, later cycles offer random k
    task automatic run_frame(input logic [3:0] kf, input logic [7:0] bits, input int vpct, input int rmode,
                             output logic [7:0] seq, output int lat);
        int in_cnt = 0, o_in = 0, out_cnt = 0, ones_out = 0, zeros_out = 0, cyc = 0;
        int first_acc = -1, first_val = -1;
        logic vld, rdy, stall_pend = 1'b0, stall_y = 1'b0, stall_last = 1'b0;
        seq = '0;
        lat = -1;
        while ((in_cnt < N || out_cnt < N) && cyc < 300) begin
            if (stall_pend) begin
                chk("stall_valid", int'(bus.y_valid), 1);
                chk("stall_y", int'(bus.y), int'(stall_y));
                chk("stall_last", int'(bus.y_last), int'(stall_last));
            end
            vld = in_cnt < N && ($urandom_range(1, 100) <= vpct);
            bus.a_valid = vld;
            bus.a = vld ? bits[N-1-in_cnt] : 1'($urandom);
            bus.k = (first_acc < 0) ? kf : 4'($urandom);
            rdy = rmode == 0 ? 1'b1 : rmode == 1 ? (cyc % 2 == 0) : ($urandom_range(1, 100) <= 60);
            bus.y_ready = rdy;
            chk("a_ready", int'(bus.a_ready), int'(in_cnt < N));
            if (first_val < 0 && bus.y_valid) first_val = cyc;
            if (bus.y_valid && rdy) begin
                if (bus.y) begin
                    ones_out++;
                    chk_le("ones_bound", ones_out, mn(int'(kf) * o_in, N));
                end else begin
                    zeros_out++;
                    chk_le("zeros_bound", zeros_out, N - mn(int'(kf) * (o_in + N - in_cnt), N));
                end
                seq[N-1-out_cnt] = bus.y;
                out_cnt++;
                chk("y_last", int'(bus.y_last), int'(out_cnt == N));
            end
            stall_pend = bus.y_valid && !rdy;
            stall_y = bus.y;
            stall_last = bus.y_last;
            if (vld && bus.a_ready) begin
                if (first_acc < 0) first_acc = cyc;
                o_in += int'(bus.a);
                in_cnt++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        bus.a_valid = 1'b0;
        bus.y_ready = 1'b0;
        chk("frame_timeout", int'(cyc >= 300), 0);
        chk("frame_ones", ones_out, mn(int'(kf) * $countones(bits), N));
        chk("post_busy", int'(busy), 0);
        chk("post_a_ready", int'(bus.a_ready), 1);
        chk("post_y_valid", int'(bus.y_valid), 0);
        if (first_acc >= 0 && first_val >= 0) lat = first_val - first_acc;
    endtask

    initial begin
        vec_t tab[7];
        logic [7:0] seq;
        int lat;
        tab[0] = '{k: 4'd2,  bits: 8'b11000000, seq: 8'b11110000, lat: 2};
        tab[1] = '{k: 4'd3,  bits: 8'b11100000, seq: 8'b11111111, lat: 2};
        tab[2] = '{k: 4'd0,  bits: 8'b10110111, seq: 8'b00000000, lat: 2};
        tab[3] = '{k: 4'd1,  bits: 8'b10101010, seq: 8'b10101010, lat: 2};
        tab[4] = '{k: 4'd1,  bits: 8'b11110000, seq: 8'b11110000, lat: 2};
        tab[5] = '{k: 4'd15, bits: 8'b00000001, seq: 8'b11111111, lat: 9};
        tab[6] = '{k: 4'd2,  bits: 8'b00000000, seq: 8'b00000000, lat: 6};
        bus.a = 1'b0;
        bus.a_valid = 1'b0;
        bus.k = '0;
        bus.y_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_y_valid", int'(bus.y_valid), 0);
        chk("rst_y", int'(bus.y), 0);
        chk("rst_y_last", int'(bus.y_last), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_a_ready", int'(bus.a_ready), 1);
        reset = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 7; t++) begin
            run_frame(tab[t].k, tab[t].bits, 100, 0, seq, lat);
            chk($sformatf("vec%0d_seq", t), int'(seq), int'(tab[t].seq));
            chk($sformatf("vec%0d_latency", t), lat, tab[t].lat);
        end
        run_frame(4'd2, 8'b10000000, 100, 1, seq, lat);
        chk("toggle_seq", int'(seq), int'(8'b11000000));
        bus.k = 4'd2;
        bus.y_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            bus.a_valid = 1'b1;
            bus.a = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        bus.a_valid = 1'b0;
        chk("pre_reset_y_valid", int'(bus.y_valid), 1);
        #2 reset = 1'b0;
        #1;
        chk("async_y_valid", int'(bus.y_valid), 0);
        chk("async_y", int'(bus.y), 0);
        chk("async_y_last", int'(bus.y_last), 0);
        chk("async_busy", int'(busy), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_frame(4'd1, 8'b10101010, 100, 0, seq, lat);
        chk("post_reset_seq", int'(seq), int'(8'b10101010));
        for (int r = 0; r < 30; r++) begin
            run_frame(4'($urandom_range(0, 15)), 8'($urandom), $urandom_range(50, 100), $urandom_range(0, 2), seq, lat);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
